// File: rtl/evp_operand_server.sv
// Operand source for the polynomial evaluation datapath: per-slot coefficient sets and degrees,
// an x FIFO, and registered N / c_i / x_b returned one cycle after each read enable.
module evp_operand_server #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned MAX_N       = 16,
  parameter int unsigned XFIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_coef_en,
  input  logic [2:0]        wr_slot,
  input  logic [4:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_coef,
  input  logic              wr_N_en,
  input  logic [4:0]        wr_N,
  input  logic              x_push,
  input  logic [DATA_W-1:0] x_in,
  output logic              x_full,
  output logic [5:0]        x_count,
  input  logic [2:0]        A,
  input  logic              en_rd_N,
  input  logic              en_rd_data,
  input  logic              en_rd_S,
  output logic [4:0]        N,
  output logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] x_b,
  output logic [3:0]        err_flags,
  input  logic              clr_err
);

  localparam int unsigned NCoef = MAX_N + 1;
  localparam int unsigned XPtrW = $clog2(XFIFO_DEPTH);
  localparam logic [4:0]  MaxN  = 5'(MAX_N);
  localparam logic [5:0]  XDepth = 6'(XFIFO_DEPTH);

  localparam int unsigned ErrUnder  = 0;
  localparam int unsigned ErrOver   = 1;
  localparam int unsigned ErrOverrun = 2;
  localparam int unsigned ErrCfg    = 3;

  // Storage without reset: contents are undefined until written.
  logic [DATA_W-1:0] coef_q [NUM_SLOTS][NCoef];
  logic [DATA_W-1:0] xmem_q [XFIFO_DEPTH];

  logic [4:0]        deg_q [NUM_SLOTS];
  logic [4:0]        deg_d [NUM_SLOTS];
  logic [XPtrW-1:0]  xwr_q, xwr_d;
  logic [XPtrW-1:0]  xrd_q, xrd_d;
  logic [5:0]        xcnt_q, xcnt_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [4:0]        n_q, n_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [DATA_W-1:0] xb_q, xb_d;
  logic [3:0]        err_q, err_d;

  logic [4:0] sel_deg;
  logic [4:0] rd_idx;
  logic       overrun;
  logic       x_empty;
  logic       x_full_int;
  logic       pop_ok;
  logic       push_ok;
  logic       deg_we;
  logic       coef_we;
  logic [3:0] err_ev;

  always_comb begin
    sel_deg = deg_q[A];
    overrun = ptr_q > sel_deg;
    // Guard the index so an overrun pointer never addresses past the slot.
    rd_idx  = overrun ? 5'd0 : ptr_q;
  end

  always_comb begin
    x_empty    = (xcnt_q == 6'd0);
    x_full_int = (xcnt_q == XDepth);
    pop_ok     = en_rd_S & ~x_empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    push_ok    = x_push & (~x_full_int | pop_ok);
    deg_we     = wr_N_en & (wr_N <= MaxN);
    coef_we    = wr_coef_en & (wr_idx <= MaxN);
  end

  always_comb begin
    err_ev             = '0;
    err_ev[ErrUnder]   = en_rd_S & x_empty;
    err_ev[ErrOver]    = x_push & x_full_int & ~en_rd_S;
    err_ev[ErrOverrun] = en_rd_data & ~en_rd_N & overrun;
    err_ev[ErrCfg]     = (wr_N_en & ~deg_we) | (wr_coef_en & ~coef_we);
  end

  always_comb begin
    n_d   = n_q;
    c_d   = c_q;
    ptr_d = ptr_q;
    if (en_rd_N) begin
      n_d   = sel_deg;
      ptr_d = 5'd0;
      if (en_rd_data) begin
        c_d   = coef_q[A][0];
        ptr_d = 5'd1;
      end
    end else if (en_rd_data) begin
      if (overrun) begin
        c_d = '0;
      end else begin
        c_d   = coef_q[A][rd_idx];
        ptr_d = ptr_q + 5'd1;
      end
    end
  end

  always_comb begin
    xb_d   = xb_q;
    xrd_d  = xrd_q;
    xwr_d  = xwr_q;
    xcnt_d = xcnt_q;
    if (pop_ok) begin
      xb_d  = xmem_q[xrd_q];
      xrd_d = xrd_q + 1'b1;
    end
    if (push_ok) begin
      xwr_d = xwr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   xcnt_d = xcnt_q + 6'd1;
      2'b01:   xcnt_d = xcnt_q - 6'd1;
      default: xcnt_d = xcnt_q;
    endcase
  end

  always_comb begin
    deg_d = deg_q;
    if (deg_we) begin
      deg_d[wr_slot] = wr_N;
    end
  end

  // A same-cycle error event overrides the clear.
  always_comb begin
    err_d = (clr_err ? 4'd0 : err_q) | err_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deg_q  <= '{default: '0};
      xwr_q  <= '0;
      xrd_q  <= '0;
      xcnt_q <= '0;
      ptr_q  <= '0;
      n_q    <= '0;
      c_q    <= '0;
      xb_q   <= '0;
      err_q  <= '0;
    end else begin
      deg_q  <= deg_d;
      xwr_q  <= xwr_d;
      xrd_q  <= xrd_d;
      xcnt_q <= xcnt_d;
      ptr_q  <= ptr_d;
      n_q    <= n_d;
      c_q    <= c_d;
      xb_q   <= xb_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (coef_we) begin
      coef_q[wr_slot][wr_idx] <= wr_coef;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      xmem_q[xwr_q] <= x_in;
    end
  end

  assign N         = n_q;
  assign c_i       = c_q;
  assign x_b       = xb_q;
  assign err_flags = err_q;
  assign x_count   = xcnt_q;
  assign x_full    = x_full_int;

endmodule

// File: doc/evp_operand_server.md
Name: evp_operand_server

Overview:
Operand source that answers the read enables (en_rd_N, en_rd_data, en_rd_S) issued by the polynomial evaluation datapath. Holds up to NUM_SLOTS coefficient sets, selected by A, each with its degree N, plus a FIFO of x values. Returns registered N, c_i and x_b one cycle after each enable. A host-side write port loads the coefficient sets and degrees and pushes x values.

Parameters:
DATA_W, 16, width of coefficients and x values
NUM_SLOTS, 8, number of coefficient sets; slot index width fixed at 3
MAX_N, 16, maximum degree; each slot stores MAX_N+1 coefficients
XFIFO_DEPTH, 32, x FIFO depth; power of two

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous active-low reset
wr_coef_en  in  1  write one coefficient
wr_slot  in  3  slot for wr_coef_en / wr_N_en
wr_idx  in  5  coefficient index 0..MAX_N
wr_coef  in  DATA_W  coefficient value
wr_N_en  in  1  write degree of wr_slot
wr_N  in  5  degree value
x_push  in  1  push x_in into the x FIFO
x_in  in  DATA_W  x value
x_full  out  1  FIFO full
x_count  out  6  FIFO occupancy, 0..XFIFO_DEPTH
A  in  3  active slot for reads
en_rd_N  in  1  read degree of slot A; rewind coefficient pointer
en_rd_data  in  1  read next coefficient of slot A
en_rd_S  in  1  pop next x
N  out  5  registered degree
c_i  out  DATA_W  registered coefficient
x_b  out  DATA_W  registered x
err_flags  out  4  sticky errors: [0] x underflow, [1] x overflow, [2] coefficient overrun, [3] config error
clr_err  in  1  clear err_flags

Behaviour:
- Reset (rst low, asynchronous): N=0, c_i=0, x_b=0, err_flags=0, coefficient pointer=0, FIFO empty (x_count=0, x_full=0), all degree-table entries=0. The coefficient memory is not reset; its contents are undefined until written.
- Read latency: the output is valid exactly 1 cycle after its enable. Every output holds its value until the next successful read of that output.
- en_rd_N: N <= deg[A]; pointer <= 0.
- en_rd_data: c_i <= coef[A][ptr]; ptr <= ptr+1.
  - If ptr > deg[A]: c_i <= 0, ptr holds, err_flags[2] set.
- en_rd_N and en_rd_data in the same cycle: the rewind takes precedence. c_i <= coef[A][0]; ptr <= 1.
- The pointer is shared across slots. Changing A without en_rd_N does not rewind it.
- en_rd_S:
  - FIFO non-empty: pop; x_b <= head.
  - FIFO empty: x_b holds; err_flags[0] set.
  - No bypass: a push and pop in the same cycle on an empty FIFO is an underflow, and the push still succeeds (count becomes 1).
- x_push:
  - Not full: write, count+1.
  - Full: value dropped; err_flags[1] set.
  - Exception: push and pop in the same cycle while full both succeed; count is unchanged.
- x_full = (x_count == XFIFO_DEPTH). Read and write pointers wrap modulo XFIFO_DEPTH.
- wr_N_en:
  - wr_N <= MAX_N: deg[wr_slot] <= wr_N.
  - Otherwise: table unchanged; err_flags[3] set.
- wr_coef_en:
  - wr_idx <= MAX_N: write the coefficient.
  - Otherwise: ignored; err_flags[3] set.
- Write and read of the same coefficient or degree entry in the same cycle: the read returns the old value; the new value is visible from the next cycle.
- err_flags are sticky. clr_err clears them. An error event in the same cycle as clr_err wins, and its bit is set.
- All enables are level-sampled per cycle. Holding en_rd_data high for k cycles reads k consecutive coefficients.

Test Plan:
- Load slot 2 with deg 3 and coefficients 5,7,9,11. Set A=2, pulse en_rd_N, then en_rd_data for 4 cycles -> N=3; c_i=5,7,9,11 on consecutive cycles, each 1 cycle after its enable; err_flags=0.
- Same setup, 5th en_rd_data -> c_i=0, err_flags[2]=1. Then en_rd_N and en_rd_data together -> c_i=5, next en_rd_data gives 7.
- Push 0x0010,0x0020, then en_rd_S for 3 cycles -> x_b=0x0010, 0x0020, then holds 0x0020; err_flags[0]=1; x_count=0.
- Push 33 values 1..33 -> x_full=1, x_count=32, err_flags[1]=1. Push and pop together while full -> count stays 32. Draining all entries returns 2..33 after the first pop of 1, confirming pointer wrap.
- wr_N=17 -> err_flags[3]=1 and deg unchanged. clr_err asserted together with an underflow -> err_flags=4'b0001.
- Assert rst low mid-stream with 5 x queued and ptr=2 -> immediately x_count=0, N=c_i=x_b=0, err_flags=0. After release, en_rd_S flags underflow.
